// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD seven-segment scan driver.
// Segment constants are active-high, bit order g..a.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUNS = 2'd2
  } digit_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high seven-segment decoder.
// Non-decimal codes show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Three-digit multiplexed 7-seg driver with frame-synchronous value commit.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in huns/tens.
module bcd_sevenseg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] huns,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       load,
  output logic       pending,
  output logic       frame_start,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_AT = CW'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_POL  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  digit_e          dig_q, dig_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap, boundary;

  logic [3:0]      disp_h, disp_t, disp_o;
  logic [3:0]      pend_h, pend_t, pend_o;
  logic            scanned;

  logic [3:0]      cur;
  logic [6:0]      dec, seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic            blank, zero_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= DIG_ONES;
      cnt_q <= '0;
    end else begin
      dig_q <= dig_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    dig_d    = dig_q;
    cnt_d    = cnt_q + 1'b1;
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (dig_q == DIG_HUNS);
    if (wrap) begin
      cnt_d = '0;
      case (dig_q)
        DIG_ONES: dig_d = DIG_TENS;
        DIG_TENS: dig_d = DIG_HUNS;
        default:  dig_d = DIG_ONES;
      endcase
    end
  end

  bcd_to_7seg u_dec (
    .bcd (cur),
    .seg (dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign zero_blank = (disp_h == 4'd0) &&
    ((dig_q == DIG_HUNS) ||
     ((dig_q == DIG_TENS) && (disp_t == 4'd0)));
`else
  assign zero_blank = 1'b0;
`endif

  always_comb begin
    cur  = disp_o;
    an_d = 3'b001;
    case (dig_q)
      DIG_TENS: begin
        cur  = disp_t;
        an_d = 3'b010;
      end
      DIG_HUNS: begin
        cur  = disp_h;
        an_d = 3'b100;
      end
      default: ;
    endcase
    blank = (cnt_q >= BLANK_AT);
    seg_d = zero_blank ? SEG_BLANK : dec;
    if (blank) begin
      an_d  = '0;
      seg_d = SEG_BLANK;
    end
  end

  // A load coinciding with the boundary bypasses the pending stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_h      <= '0;
      disp_t      <= '0;
      disp_o      <= '0;
      pend_h      <= '0;
      pend_t      <= '0;
      pend_o      <= '0;
      pending     <= 1'b0;
      scanned     <= 1'b0;
      frame_start <= 1'b0;
      an          <= AN_POL;
      seg         <= SEG_POL;
    end else begin
      if (load && boundary) begin
        disp_h  <= huns;
        disp_t  <= tens;
        disp_o  <= ones;
        pending <= 1'b0;
      end else if (load) begin
        pend_h  <= huns;
        pend_t  <= tens;
        pend_o  <= ones;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        disp_h  <= pend_h;
        disp_t  <= pend_t;
        disp_o  <= pend_o;
        pending <= 1'b0;
      end
      if (boundary) scanned <= 1'b1;
      frame_start <= scanned &&
        (dig_q == DIG_ONES) && (cnt_q == '0);
      an  <= an_d ^ AN_POL;
      seg <= seg_d ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench for bcd_sevenseg_scan (REFRESH_DIV=8, BLANK_CYCLES=2).
// Expected frames are queued by stimulus and checked cycle by cycle.
module tb_bcd_sevenseg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] L0 = 7'h40;
  localparam logic [6:0] L1 = 7'h79;
  localparam logic [6:0] L2 = 7'h24;
  localparam logic [6:0] L5 = 7'h12;
  localparam logic [6:0] L7 = 7'h78;
  localparam logic [6:0] L8 = 7'h00;
  localparam logic [6:0] L9 = 7'h10;
  localparam logic [6:0] LD = 7'h3F;
  localparam logic [6:0] LB = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = LB;
`else
  localparam logic [6:0] LZ = L0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] huns = '0;
  logic [3:0] tens = '0;
  logic [3:0] ones = '0;
  logic       pending;
  logic       frame_start;
  logic [2:0] an;
  logic [6:0] seg;

  bcd_sevenseg_scan #(
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .huns        (huns),
    .tens        (tens),
    .ones        (ones),
    .load        (load),
    .pending     (pending),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] o;
    logic [6:0] t;
    logic [6:0] h;
  } frame_t;

  frame_t exp_q[$];
  bit     mon_busy = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: got timeout want frame_start");
    end
  endtask

  task automatic drive(logic [3:0] h, logic [3:0] t, logic [3:0] o);
    huns = h;
    tens = t;
    ones = o;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    frame_t     f;
    logic [6:0] s;
    logic [2:0] a;
    int         slot;
    int         pos;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1 && exp_q.size() > 0) begin
        mon_busy = 1'b1;
        f = exp_q.pop_front();
        for (int k = 0; k < 3 * RD; k++) begin
          if (k > 0) @(negedge clk);
          slot = k / RD;
          pos  = k % RD;
          if (pos < RD - BC) begin
            a = 3'b111 ^ (3'b001 << slot);
            s = (slot == 0) ? f.o : (slot == 1) ? f.t : f.h;
          end else begin
            a = 3'b111;
            s = LB;
          end
          chk($sformatf("frame cyc %0d {fs,an,seg}", k),
              {21'd0, frame_start, an, seg},
              {21'd0, (k == 0), a, s});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int n;

    rst = 1'b1;
    step(3);
    chk("rst an", an, 3'b111);
    chk("rst seg", seg, LB);
    chk("rst pending", pending, 0);
    chk("rst fs", frame_start, 0);
    rst = 1'b0;
    step(1);
    chk("first an", an, 3'b110);
    chk("first seg", seg, L0);
    wait_fs(n);
    chk("first fs delay", n, 24);

    step(4);
    drive(4'd2, 4'd5, 4'd5);
    chk("load pending", pending, 1);
    exp_q.push_back('{o: L5, t: L5, h: L2});
    step(16);
    chk("pending hold", pending, 1);
    step(2);
    chk("pending commit", pending, 0);

    wait_fs(n);
    step(2);
    drive(4'd1, 4'd2, 4'd3);
    step(3);
    drive(4'd0, 4'd0, 4'd9);
    chk("reload pending", pending, 1);
    exp_q.push_back('{o: L9, t: LZ, h: LZ});

    wait_fs(n);
    step(22);
    drive(4'd8, 4'd8, 4'd8);
    chk("boundary load pending", pending, 0);
    exp_q.push_back('{o: L8, t: L8, h: L8});

    wait_fs(n);
    step(2);
    drive(4'd1, 4'd0, 4'hC);
    exp_q.push_back('{o: LD, t: L0, h: L1});
    wait_fs(n);
    step(2);
    drive(4'd0, 4'd0, 4'd7);
    exp_q.push_back('{o: L7, t: LZ, h: LZ});
    wait_fs(n);
    wait_fs(n);

    step(2);
    drive(4'd2, 4'd5, 4'd5);
    chk("pre-reset pending", pending, 1);
    step(14);
    rst = 1'b1;
    step(1);
    chk("midrst an", an, 3'b111);
    chk("midrst seg", seg, LB);
    chk("midrst pending", pending, 0);
    chk("midrst fs", frame_start, 0);
    rst = 1'b0;
    step(1);
    chk("restart an", an, 3'b110);
    chk("restart seg", seg, L0);
    exp_q.push_back('{o: L0, t: LZ, h: LZ});
    wait_fs(n);
    chk("restart fs delay", n, 24);

    for (int i = 0; i < 100 && (exp_q.size() > 0 || mon_busy); i++)
      step(1);
    if (exp_q.size() > 0 || mon_busy) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
